rr_arbiter_requester_2ch: RTL and testbench
===========================================

Name: rr_arbiter_requester_2ch

Overview:
- Requester-side front end for the two-request round-robin arbiter.
- Two independent producer channels each push words into a private FIFO.
- Each non-empty FIFO raises its bit of `requests`; the external arbiter answers on `grants`.
- The granted head word is popped and presented on one registered output with a source tag. Illegal grants are detected and flagged.

Parameters:
- W, 8, data word width in bits.
- DEPTH, 4, per-channel FIFO depth in words; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in0_valid  input  1  channel 0 word offered.
- in0_data  input  W  channel 0 word.
- in0_ready  output  1  channel 0 can accept.
- in1_valid  input  1  channel 1 word offered.
- in1_data  input  W  channel 1 word.
- in1_ready  output  1  channel 1 can accept.
- requests  output  2  bit i = FIFO i non-empty; drives the arbiter.
- grants  input  2  arbiter response, same cycle as `requests`.
- out_valid  output  1  registered; one word delivered this cycle.
- out_data  output  W  delivered word.
- out_src  output  1  channel index of `out_data`.
- error  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_n low, asynchronous), both FIFOs empty:
  - requests=00, in0_ready=in1_ready=1.
  - out_valid=0, out_data=0, out_src=0, error=0.
- Reset asserted mid-operation discards all buffered words immediately.
- FIFO storage:
  - Each channel has a circular buffer with read/write pointers of log2(DEPTH) bits that wrap naturally.
  - Each channel has a count of log2(DEPTH)+1 bits.
- Push: word accepted on the rising edge where inX_valid && inX_ready.
  - inX_ready = (countX != DEPTH), driven from registered count only.
  - When full, ready=0 even if a pop occurs the same cycle; no push-through.
- requests[i] = (count_i != 0), driven from registered state; no combinational path from grants.
- Legal grant: grants is 01 or 10, and the granted bit's request is 1.
  - Pop the head of that FIFO at the clock edge.
  - Next cycle: out_valid=1, out_data=popped word, out_src=granted index. Latency is 1 cycle from grant to output.
- Non-pop cycle: out_valid=0. out_data and out_src hold their last value.
- No output backpressure; the downstream sink always accepts.
- Simultaneous push and pop on the same channel: count unchanged, both pointers advance.
  - Allowed whenever the FIFO is not full.
- A push into an empty FIFO raises its request on the next cycle. Minimum input-to-output latency is 2 cycles.
- Illegal grant: grants == 11, or grants[i]=1 while requests[i]=0.
  - No pop on either channel.
  - out_valid=0 next cycle.
  - error set next cycle; remains 1 until reset.
- grants == 00: no pop, no error.

Optional Feature:
- Macro: RR_REQUESTER_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (each 16 bits).
  - Each counts legal pops for its channel.
  - Counters saturate at 16'hFFFF and reset to 0.
- Not defined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle:
  - Hold rst_n=0 for 3 cycles, release, all inputs 0.
  - Expect requests=00, in0_ready=in1_ready=1, out_valid=0, error=0 for 10 cycles.
- Single channel stream:
  - Push 8'hA1, 8'hA2 on ch0 with grants mirroring requests.
  - Expect out_valid pulses carrying A1 then A2, both with out_src=0, each 1 cycle after its grant.
  - Expect requests back to 00 afterwards.
- Full boundary:
  - With DEPTH=4 and grants=00, push 5 words on ch1.
  - Expect in1_ready=0 after the 4th accept; the 5th word is not taken.
  - Then grant 10 once: in1_ready returns to 1 the next cycle and out_data = the 1st word.
- Alternation with a reference arbiter model:
  - Both FIFOs are loaded (ch0: 10,11,12; ch1: 20,21,22).
  - Expect out_data sequence 10,20,11,21,12,22 and out_src 0,1,0,1,0,1.
- Illegal grants:
  - Apply grants=11 with both requests high: expect no pop, out_valid=0, error=1 next cycle and sticky.
  - After reset, apply grants=01 with the ch0 FIFO empty: expect error=1.
- Async reset mid-stream:
  - Drop rst_n between clock edges while ch0 holds 3 words.
  - Expect requests=00 and out_valid=0 immediately without waiting for a clock edge, and the FIFO empty after release.
  - With RR_REQUESTER_STATS_EN defined, grant_cnt0 returns to 0.

Source files
------------

// File: rtl/rr_arbiter_requester_2ch.sv
// rtl/rr_arbiter_requester_2ch.sv - two-channel FIFO requester front end for a round-robin arbiter (optional RR_REQUESTER_STATS_EN)
module rr_arbiter_requester_2ch #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in0_valid,
   input  logic [W-1:0] in0_data,
   output logic         in0_ready,
   input  logic         in1_valid,
   input  logic [W-1:0] in1_data,
   output logic         in1_ready,
   output logic [1:0]   requests,
   input  logic [1:0]   grants,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_src,
   output logic         error
`ifdef RR_REQUESTER_STATS_EN
   ,
   output logic [15:0]  grant_cnt0,
   output logic [15:0]  grant_cnt1
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem    [2][DEPTH];
   logic [AW-1:0] wr_ptr [2];
   logic [AW-1:0] rd_ptr [2];
   logic [AW:0]   count  [2];
   logic [W-1:0]  in_data [2];
   logic [1:0]    in_valid;
   logic [1:0]    push;
   logic [1:0]    pop;
   logic          illegal;

   assign in_valid   = {in1_valid, in0_valid};
   assign in_data[0] = in0_data;
   assign in_data[1] = in1_data;

   // Ready and request come only from registered counts, so grants never feed back combinationally.
   assign in0_ready   = (count[0] != FULL);
   assign in1_ready   = (count[1] != FULL);
   assign requests[0] = (count[0] != '0);
   assign requests[1] = (count[1] != '0);

   assign push    = in_valid & {in1_ready, in0_ready};
   assign pop[0]  = (grants == 2'b01) && requests[0];
   assign pop[1]  = (grants == 2'b10) && requests[1];
   assign illegal = (grants == 2'b11) || ((grants & ~requests) != 2'b00);

   // Word storage; contents are don't-care while empty, so no reset is needed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) begin
            mem[i][wr_ptr[i]] <= in_data[i];
         end
      end
   end

   // Pointers and occupancy; reset discards any buffered words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
               wr_ptr[i] <= wr_ptr[i] + AW'(1);
            end
            if (pop[i]) begin
               rd_ptr[i] <= rd_ptr[i] + AW'(1);
            end
            count[i] <= count[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
         end
      end
   end

   // Registered delivery of the popped head word; data and tag hold between pops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= 1'b0;
      end else begin
         out_valid <= pop[0] | pop[1];
         if (pop[0]) begin
            out_data <= mem[0][rd_ptr[0]];
            out_src  <= 1'b0;
         end else if (pop[1]) begin
            out_data <= mem[1][rd_ptr[1]];
            out_src  <= 1'b1;
         end
      end
   end

   // Sticky protocol-violation flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error <= 1'b0;
      end else if (illegal) begin
         error <= 1'b1;
      end
   end

`ifdef RR_REQUESTER_STATS_EN
   // Saturating per-channel counts of legal pops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (pop[0] && (grant_cnt0 != 16'hFFFF)) begin
            grant_cnt0 <= grant_cnt0 + 16'd1;
         end
         if (pop[1] && (grant_cnt1 != 16'hFFFF)) begin
            grant_cnt1 <= grant_cnt1 + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rr_arbiter_requester_2ch.sv
// tb/tb_rr_arbiter_requester_2ch.sv - randomized self-checking bench with queue-based reference model
module tb_rr_arbiter_requester_2ch;

   localparam int W     = 8;
   localparam int DEPTH = 4;

   logic         clk;
   logic         rst_n;
   logic         in0_valid;
   logic [W-1:0] in0_data;
   logic         in0_ready;
   logic         in1_valid;
   logic [W-1:0] in1_data;
   logic         in1_ready;
   logic [1:0]   requests;
   logic [1:0]   grants;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_src;
   logic         error;
`ifdef RR_REQUESTER_STATS_EN
   logic [15:0]  grant_cnt0;
   logic [15:0]  grant_cnt1;
`endif

   rr_arbiter_requester_2ch #(.W(W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
      .requests  (requests),
      .grants    (grants),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .error     (error)
`ifdef RR_REQUESTER_STATS_EN
      ,
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference model: queues hold buffered words, scalars hold the expected registered outputs.
   logic [W-1:0] mq0[$];
   logic [W-1:0] mq1[$];
   logic         m_ov;
   logic [W-1:0] m_od;
   logic         m_os;
   logic         m_err;
   logic         rr_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq0.delete();
      mq1.delete();
      m_ov    = 1'b0;
      m_od    = '0;
      m_os    = 1'b0;
      m_err   = 1'b0;
      rr_last = 1'b1;
   endtask

   function automatic logic [1:0] rr_grant();
      bit r0, r1;
      r0 = (mq0.size() != 0);
      r1 = (mq1.size() != 0);
      if (r0 && r1) return (rr_last == 1'b0) ? 2'b10 : 2'b01;
      if (r0) return 2'b01;
      if (r1) return 2'b10;
      return 2'b00;
   endfunction

   // Advance the model across one rising edge using the inputs currently driven.
   task automatic model_edge();
      bit r0, r1, f0, f1;
      r0 = (mq0.size() != 0);
      r1 = (mq1.size() != 0);
      f0 = (mq0.size() == DEPTH);
      f1 = (mq1.size() == DEPTH);
      if (grants == 2'b11 || (grants[0] && !r0) || (grants[1] && !r1)) m_err = 1'b1;
      m_ov = 1'b0;
      if (grants == 2'b01 && r0) begin
         m_ov = 1'b1; m_od = mq0.pop_front(); m_os = 1'b0; rr_last = 1'b0;
      end else if (grants == 2'b10 && r1) begin
         m_ov = 1'b1; m_od = mq1.pop_front(); m_os = 1'b1; rr_last = 1'b1;
      end
      if (in0_valid && !f0) mq0.push_back(in0_data);
      if (in1_valid && !f1) mq1.push_back(in1_data);
   endtask

   task automatic step(input logic a0, input logic [W-1:0] b0, input logic a1,
                       input logic [W-1:0] b1, input logic [1:0] gr);
      in0_valid = a0;
      in0_data  = b0;
      in1_valid = a1;
      in1_data  = b1;
      grants    = gr;
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      in0_valid = 1'b0; in1_valid = 1'b0; grants = 2'b00;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Every cycle out of reset, compare all DUT outputs with the model just after the edge.
   always @(posedge clk) begin
      #2;
      if (chk_en && rst_n) begin
         chk("requests", 32'(requests), 32'({mq1.size() != 0, mq0.size() != 0}));
         chk("in0_ready", 32'(in0_ready), 32'(mq0.size() != DEPTH));
         chk("in1_ready", 32'(in1_ready), 32'(mq1.size() != DEPTH));
         chk("out_valid", 32'(out_valid), 32'(m_ov));
         chk("out_data", 32'(out_data), 32'(m_od));
         chk("out_src", 32'(out_src), 32'(m_os));
         chk("error", 32'(error), 32'(m_err));
      end
   end

   logic [W-1:0] alt_data [6];
   logic         alt_src  [6];

   initial begin
      alt_data = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
      alt_src  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      rst_n = 1'b0;
      in0_valid = 1'b0; in0_data = '0; in1_valid = 1'b0; in1_data = '0; grants = 2'b00;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_requests", 32'(requests), 32'h0);
      chk("rst_in0_ready", 32'(in0_ready), 32'h1);
      chk("rst_in1_ready", 32'(in1_ready), 32'h1);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_error", 32'(error), 32'h0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Idle after reset.
      repeat (10) step(1'b0, '0, 1'b0, '0, 2'b00);
      chk("idle_requests", 32'(requests), 32'h0);

      // Single channel stream.
      step(1'b1, 8'hA1, 1'b0, '0, 2'b00);
      chk("s_req", 32'(requests), 32'h1);
      step(1'b1, 8'hA2, 1'b0, '0, 2'b01);
      chk("s_ov1", 32'(out_valid), 32'h1);
      chk("s_od1", 32'(out_data), 32'hA1);
      chk("s_src1", 32'(out_src), 32'h0);
      step(1'b0, '0, 1'b0, '0, 2'b01);
      chk("s_od2", 32'(out_data), 32'hA2);
      step(1'b0, '0, 1'b0, '0, 2'b00);
      chk("s_req_end", 32'(requests), 32'h0);
      chk("s_ov_end", 32'(out_valid), 32'h0);

      // Full boundary on channel 1.
      for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 8'(8'h31 + k), 2'b00);
      chk("f_ready0", 32'(in1_ready), 32'h0);
      step(1'b0, '0, 1'b1, 8'h35, 2'b00);
      chk("f_ready1", 32'(in1_ready), 32'h0);
      step(1'b0, '0, 1'b0, '0, 2'b10);
      chk("f_ready2", 32'(in1_ready), 32'h1);
      chk("f_od", 32'(out_data), 32'h31);
      chk("f_src", 32'(out_src), 32'h1);
      repeat (5) step(1'b0, '0, 1'b0, '0, rr_grant());
      chk("f_drained", 32'(requests), 32'h0);

      // Alternation under a round-robin arbiter that favours channel 0 first.
      for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h10 + k), 1'b1, 8'(8'h20 + k), 2'b00);
      rr_last = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step(1'b0, '0, 1'b0, '0, rr_grant());
         chk("alt_data", 32'(out_data), 32'(alt_data[k]));
         chk("alt_src", 32'(out_src), 32'(alt_src[k]));
      end
      chk("alt_error", 32'(error), 32'h0);

      // Illegal grants.
      step(1'b1, 8'h40, 1'b1, 8'h50, 2'b00);
      step(1'b0, '0, 1'b0, '0, 2'b11);
      chk("ill_ov", 32'(out_valid), 32'h0);
      chk("ill_err", 32'(error), 32'h1);
      chk("ill_req", 32'(requests), 32'h3);
      step(1'b0, '0, 1'b0, '0, 2'b00);
      chk("ill_sticky", 32'(error), 32'h1);
      do_reset();
      step(1'b0, '0, 1'b0, '0, 2'b01);
      chk("ill_empty_err", 32'(error), 32'h1);
      chk("ill_empty_ov", 32'(out_valid), 32'h0);

      // Asynchronous reset mid-stream.
      do_reset();
      step(1'b1, 8'h61, 1'b0, '0, 2'b00);
      step(1'b1, 8'h62, 1'b0, '0, 2'b00);
      step(1'b1, 8'h63, 1'b0, '0, 2'b00);
      step(1'b1, 8'h64, 1'b0, '0, 2'b01);
      chk("ar_ov_before", 32'(out_valid), 32'h1);
      in0_valid = 1'b0; grants = 2'b00;
      #2 rst_n = 1'b0;
      #1;
      chk("ar_req", 32'(requests), 32'h0);
      chk("ar_ov", 32'(out_valid), 32'h0);
      chk("ar_ready", 32'(in0_ready), 32'h1);
`ifdef RR_REQUESTER_STATS_EN
      chk("ar_cnt0", 32'(grant_cnt0), 32'h0);
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, '0, 1'b0, '0, 2'b00);
      chk("ar_req_after", 32'(requests), 32'h0);

      // Randomized traffic: heavy input then heavy drain, occasional arbitrary grants.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         int r;
         logic [1:0] gg;
         logic a0, a1;
         r = int'($urandom_range(0, 19));
         if (r == 0) gg = 2'($urandom_range(0, 3));
         else if (r < ((n < 300) ? 12 : 3)) gg = 2'b00;
         else gg = rr_grant();
         if (n < 300) begin
            a0 = ($urandom_range(0, 3) != 0);
            a1 = ($urandom_range(0, 3) != 0);
         end else begin
            a0 = ($urandom_range(0, 3) == 0);
            a1 = ($urandom_range(0, 3) == 0);
         end
         step(a0, 8'($urandom), a1, 8'($urandom), gg);
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
